// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: EX and SLB results queue in per-source FIFOs and
// a round-robin grant drains one entry per cycle onto a registered broadcast port.
module cdb_arbiter #(
    parameter int NICK_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [DATA_W-1:0] iEX_dt,
    output logic              oEX_full,
    input  logic              iSLB_en,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [DATA_W-1:0] iSLB_dt,
    output logic              oSLB_full,
    output logic              oCDB_en,
    output logic [NICK_W-1:0] oCDB_nick,
    output logic [DATA_W-1:0] oCDB_dt,
    output logic              oCDB_src,
    output logic              oOVF
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = NICK_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);
    localparam logic SRC_EX  = 1'b0;
    localparam logic SRC_SLB = 1'b1;

    // Index 0 is EX, index 1 is SLB, matching the oCDB_src encoding.
    logic [1:0]        in_en;
    logic [NICK_W-1:0] in_nick   [2];
    logic [DATA_W-1:0] in_dt     [2];
    logic [1:0]        push;
    logic [1:0]        drop_full;
    logic [1:0]        pop;
    logic [1:0]        not_empty;
    logic [1:0]        full_flag;
    logic [NICK_W-1:0] head_nick [2];
    logic [DATA_W-1:0] head_dt   [2];

    assign in_en      = {iSLB_en, iEX_en};
    assign in_nick[0] = iEX_nick;
    assign in_nick[1] = iSLB_nick;
    assign in_dt[0]   = iEX_dt;
    assign in_dt[1]   = iSLB_dt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem_q [DEPTH];
            logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             full_q, full_d;
            logic             want;

            // nick 0 means "no destination": never queued, never an overflow.
            assign want          = in_en[gi] && (in_nick[gi] != '0);
            assign push[gi]      = rdy && !clr && want && (cnt_q != CNT_FULL);
            assign drop_full[gi] = rdy && !clr && want && (cnt_q == CNT_FULL);
            assign not_empty[gi] = (cnt_q != '0);
            assign full_flag[gi] = full_q;
            assign head_nick[gi] = mem_q[rd_ptr_q][ENT_W-1:DATA_W];
            assign head_dt[gi]   = mem_q[rd_ptr_q][DATA_W-1:0];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                cnt_d    = cnt_q;
                full_d   = full_q;
                if (clr) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                    full_d   = 1'b0;
                end else if (rdy) begin
                    if (push[gi]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (pop[gi])  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    cnt_d  = cnt_q + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
                    // One slot of slack covers the push issued against a stale flag.
                    full_d = (cnt_d >= CNT_ALMOST);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                    full_q   <= 1'b0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                    full_q   <= full_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push[gi]) mem_q[wr_ptr_q] <= {in_nick[gi], in_dt[gi]};
            end
        end
    endgenerate

    logic              rr_last_q, rr_last_d;
    logic              cdb_en_q, cdb_en_d;
    logic [NICK_W-1:0] cdb_nick_q, cdb_nick_d;
    logic [DATA_W-1:0] cdb_dt_q, cdb_dt_d;
    logic              cdb_src_q, cdb_src_d;
    logic              ovf_q, ovf_d;
    logic              grant_src;

    always_comb begin
        pop        = '0;
        grant_src  = SRC_EX;
        rr_last_d  = rr_last_q;
        cdb_en_d   = 1'b0;
        cdb_nick_d = cdb_nick_q;
        cdb_dt_d   = cdb_dt_q;
        cdb_src_d  = cdb_src_q;
        ovf_d      = ovf_q;
        if (clr) begin
            rr_last_d  = SRC_SLB;
            cdb_nick_d = '0;
            cdb_dt_d   = '0;
            cdb_src_d  = 1'b0;
        end else if (!rdy) begin
            cdb_nick_d = '0;
            cdb_dt_d   = '0;
            cdb_src_d  = 1'b0;
        end else begin
            if (&not_empty) grant_src = ~rr_last_q;
            else            grant_src = not_empty[1] ? SRC_SLB : SRC_EX;
            if (|not_empty) begin
                pop[grant_src] = 1'b1;
                rr_last_d      = grant_src;
                cdb_en_d       = 1'b1;
                cdb_nick_d     = head_nick[grant_src];
                cdb_dt_d       = head_dt[grant_src];
                cdb_src_d      = grant_src;
            end
            if (|drop_full) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q  <= SRC_SLB;
            cdb_en_q   <= 1'b0;
            cdb_nick_q <= '0;
            cdb_dt_q   <= '0;
            cdb_src_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rr_last_q  <= rr_last_d;
            cdb_en_q   <= cdb_en_d;
            cdb_nick_q <= cdb_nick_d;
            cdb_dt_q   <= cdb_dt_d;
            cdb_src_q  <= cdb_src_d;
            ovf_q      <= ovf_d;
        end
    end

    assign oEX_full  = full_flag[0];
    assign oSLB_full = full_flag[1];
    assign oCDB_en   = cdb_en_q;
    assign oCDB_nick = cdb_nick_q;
    assign oCDB_dt   = cdb_dt_q;
    assign oCDB_src  = cdb_src_q;
    assign oOVF      = ovf_q;
endmodule
